// File: rtl/dm_slave_mc_if.sv
// Bus between a multicycle CPU and the data-memory slave.
// req is sampled only while the slave is idle; the slave answers with a single-cycle
// ready pulse, and rdata/err are meaningful only while ready=1 (rdata is held afterwards).
interface dm_slave_mc_if;
    logic        req;
    logic        we;
    logic [1:0]  wbits;
    logic [2:0]  rbits;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, wbits, rbits, addr, wdata,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, wbits, rbits, addr, wdata,
        output ready, rdata, err
    );
endinterface

// File: rtl/dm_slave_mc.sv
// Multicycle data-memory slave: captures a request, waits LATENCY cycles, performs a
// sized little-endian load/store on a 2^AW x 32 array, and pulses ready for one cycle.
module dm_slave_mc #(
    parameter int LATENCY = 2,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    dm_slave_mc_if.slave  bus,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [3:0] LAT     = 4'(LATENCY);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic [31:0]  rdata_q;
    logic         we_q;
    logic [1:0]   wbits_q;
    logic [2:0]   rbits_q;
    logic [AW+1:0] addr_q;
    logic [31:0]  wdata_q;

    logic         capture;
    logic         access;
    logic [1:0]   req_size;
    logic         req_misaligned;

    logic [31:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] idx;
    logic [3:0]   be;
    logic [31:0]  wlane;
    logic [31:0]  rd_word;
    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;
    logic [31:0]  rd_value;

    logic unused_addr;
    assign unused_addr = ^bus.addr[31:AW+2];

    // Access size is judged from the live inputs so the misalignment decision is
    // made in the same edge that captures the request.
    always_comb begin
        req_size = SZ_WORD;
        if (bus.we) begin
            case (bus.wbits)
                2'b01:   req_size = SZ_HALF;
                2'b10:   req_size = SZ_BYTE;
                default: req_size = SZ_WORD;
            endcase
        end else begin
            case (bus.rbits)
                3'b001, 3'b010: req_size = SZ_HALF;
                3'b011, 3'b100: req_size = SZ_BYTE;
                default:        req_size = SZ_WORD;
            endcase
        end
        req_misaligned = ((req_size == SZ_WORD) && (bus.addr[1:0] != 2'b00)) ||
                         ((req_size == SZ_HALF) && bus.addr[0]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    capture = 1'b1;
                    if (req_misaligned) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                        err_d   = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            wbits_q <= 2'd0;
            rbits_q <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (capture) begin
                we_q    <= bus.we;
                wbits_q <= bus.wbits;
                rbits_q <= bus.rbits;
                addr_q  <= bus.addr[AW+1:0];
                wdata_q <= bus.wdata;
            end
            if (access && !we_q) begin
                rdata_q <= rd_value;
            end
        end
    end

    assign idx = addr_q[AW+1:2];

    // Write data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        case (wbits_q)
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (access && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (rbits_q)
            3'b001:  rd_value = {{16{rd_half[15]}}, rd_half};
            3'b010:  rd_value = {16'd0, rd_half};
            3'b011:  rd_value = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_value = {24'd0, rd_byte};
            default: rd_value = rd_word;
        endcase
    end

    assign bus.ready = (state_q == RESP);
    assign bus.err   = (state_q == RESP) && err_q;
    assign bus.rdata = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: doc/dm_slave_mc.md
DM_SLAVE_MC -- requirements
Module: dm_slave_mc

Interface
REQ-001 Parameter LATENCY, default 2, wait cycles inserted between request capture and the memory access (legal range 0..15).
REQ-002 Parameter AW, default 8, log2 of the word depth; the array holds 2^AW words of 32 bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  access request from the multicycle CPU; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 wbits  input  2  write size: 00 word, 01 halfword, 10 byte; 11 is treated as word.
REQ-008 rbits  input  3  read size and extension: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101..111 are treated as lw.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  write data; stored from the low bits.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  read result; valid while ready=1, held until the next completion.
REQ-013 err  output  1  misaligned-access flag; valid while ready=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE, when req=1 at an edge, the block SHALL capture addr, we, wbits, rbits and wdata into internal registers.
REQ-016 Alignment rule: a word access with addr[1:0]!=0 is misaligned; a halfword access with addr[0]=1 is misaligned; byte accesses are always aligned.
REQ-017 Misaligned capture SHALL go IDLE->RESP with err=1; memory is unchanged and rdata keeps its previous value.
REQ-018 Aligned capture SHALL go IDLE->WAIT and load the wait counter with LATENCY.
REQ-019 In WAIT, the counter SHALL decrement each edge while it is nonzero; at the edge where it is zero, the access is performed and the FSM goes to RESP.
REQ-020 Latency: for a request captured at edge k, ready SHALL be high during the cycle after edge k+LATENCY+1 and low otherwise; for a misaligned request, ready SHALL be high during the cycle after edge k.
REQ-021 RESP SHALL last exactly one cycle and then return to IDLE; a req present during that RESP cycle is not captured, so back-to-back requests need at least one IDLE cycle.
REQ-022 req SHALL be ignored in WAIT and RESP, and captured values SHALL NOT change after capture.
REQ-023 Word index: the index SHALL be addr[AW+1:2]; upper address bits are ignored, so accesses wrap modulo the depth.
REQ-024 Byte lanes are little-endian: byte offset 0 maps to bits 7:0 and halfword offset 2 maps to bits 31:16.
REQ-025 A write SHALL update only the selected lanes: byte writes store wdata[7:0], halfword writes store wdata[15:0]; other lanes are preserved.
REQ-026 A read SHALL extract the selected lane; lh and lb sign-extend, lhu and lbu zero-extend.
REQ-027 rdata SHALL be updated only at the access edge of an aligned read; writes leave rdata unchanged.
REQ-028 err SHALL be 0 for every aligned completion.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, counter=0, ready=0, err=0 and rdata=0.
REQ-030 Reset during WAIT SHALL abort the pending access; no memory write occurs.
REQ-031 Memory contents are not cleared by reset and are undefined until written.
REQ-032 After rst rises, the first edge with req=1 SHALL be captured normally.

Verification
REQ-033 LATENCY=2: sw 0x11223344 to addr 0x10, then lw 0x10 -> ready 3 cycles after each capture edge, rdata=0x11223344, err=0.
REQ-034 After REQ-033: sb wdata=0xAB to 0x11, then lw 0x10 -> 0x1122AB44; lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB.
REQ-035 sh wdata=0x8001 to 0x12, then lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001; lw 0x10 -> 0x8001AB44.
REQ-036 lw at 0x13 and sh at 0x11 -> ready and err high 1 cycle after capture; memory and rdata unchanged.
REQ-037 Reset asserted one cycle after a sw capture -> ready stays 0; after release, lw of the same address returns the old word.
REQ-038 LATENCY=0 with req held high continuously -> ready pulses every 3 cycles, and AW wrap: addr 0x400 aliases 0x000 when AW=8.
